// File: rtl/hazard_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_pkg
// Shared pipeline definitions for the hazard controller.
//   md_state_t : mult/div sequencer state (RUN = 0, MD_BUSY = 1)
//   REG_W      : register-address width
//   REG_ZERO   : hard-wired zero register ($zero), never a real producer
// ---------------------------------------------------------------------------
package hazard_control_unit_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_if
// Pipeline-to-hazard-unit signal bundle.
//   master : pipeline side, drives ID/EX status, receives control
//   slave  : hazard unit side
// Signals:
//   id_rs, id_rt, id_uses_rs, id_uses_rt : ID source operands
//   id_is_muldiv, id_reads_hilo          : ID mult/div and mfhi/mflo flags
//   ex_mem_read, ex_rd, ex_branch_taken  : EX load / destination / redirect
//   pc_write, if_id_write, if_id_flush, id_ex_bubble : pipeline control
//   muldiv_start, muldiv_busy            : mult/div unit issue and status
// ---------------------------------------------------------------------------
interface hazard_control_unit_if;
   import hazard_control_unit_pkg::*;

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             id_is_muldiv;
   logic             id_reads_hilo;
   logic             ex_mem_read;
   logic [REG_W-1:0] ex_rd;
   logic             ex_branch_taken;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic             muldiv_start;
   logic             muldiv_busy;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv,
             id_reads_hilo, ex_mem_read, ex_rd, ex_branch_taken,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
             muldiv_start, muldiv_busy
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv,
             id_reads_hilo, ex_mem_read, ex_rd, ex_branch_taken,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble,
             muldiv_start, muldiv_busy
   );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// CNT_W-bit up-counter that sticks at all-ones.
//   clk, rst : clock, asynchronous active-high reset (clears to 0)
//   inc      : increment enable
//   cnt      : current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
// Resolves hazards the EX forwarding network cannot: load-use stalls,
// wrong-path flush on taken branches/jumps, and mult/div sequencing so
// HI/LO readers wait until the result is valid.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : hazard_control_unit_if.slave (ID/EX status in, control out)
//   stall_cnt : cycles stalled (saturating)       [HAZARD_PERF_CNT_EN only]
//   flush_cnt : cycles flushed (saturating)       [HAZARD_PERF_CNT_EN only]
// ---------------------------------------------------------------------------
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   hazard_control_unit_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
`endif
);

   localparam int MD_W = $clog2(MULDIV_LAT + 1);

   if ((MULDIV_LAT < 1) || (MULDIV_LAT > 15) || (CNT_W < 1)) begin : g_bad_param
      $error("hazard_control_unit: MULDIV_LAT must be 1..15 and CNT_W >= 1");
   end

   md_state_t        state, state_nxt;
   logic [MD_W-1:0]  md_cnt, md_cnt_nxt;
   logic             load_use;
   logic             md_hazard;
   logic             stall;

   always_comb begin
      load_use  = bus.ex_mem_read && (bus.ex_rd != REG_ZERO) &&
                  ((bus.id_uses_rs && (bus.ex_rd == bus.id_rs)) ||
                   (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
      md_hazard = (state == MD_BUSY) && (bus.id_is_muldiv || bus.id_reads_hilo);
      // A taken branch squashes the ID instruction, so its hazards are moot.
      stall     = (load_use || md_hazard) && !bus.ex_branch_taken;
   end

   always_comb begin
      bus.pc_write     = 1'b1;
      bus.if_id_write  = 1'b1;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_bubble = 1'b0;
      if (bus.ex_branch_taken) begin
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
      end else if (stall) begin
         bus.pc_write     = 1'b0;
         bus.if_id_write  = 1'b0;
         bus.id_ex_bubble = 1'b1;
      end
      bus.muldiv_start = bus.id_is_muldiv && (state == RUN) && !stall &&
                         !bus.ex_branch_taken;
      bus.muldiv_busy  = (state == MD_BUSY);
   end

   // Mult/div sequencer: a branch never aborts MD_BUSY, the issued op is older.
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      case (state)
         RUN: begin
            if (bus.muldiv_start) begin
               state_nxt  = MD_BUSY;
               md_cnt_nxt = MD_W'(MULDIV_LAT);
            end
         end
         MD_BUSY: begin
            if (md_cnt == MD_W'(1)) begin
               state_nxt  = RUN;
               md_cnt_nxt = '0;
            end else begin
               md_cnt_nxt = md_cnt - MD_W'(1);
            end
         end
         default: begin
            state_nxt  = RUN;
            md_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (bus.ex_branch_taken),
      .cnt (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed bench for hazard_control_unit (MULDIV_LAT = 4, CNT_W = 4).
// Control outputs are compared as one packed vector:
//   {pc_write, if_id_write, if_id_flush, id_ex_bubble, muldiv_start, muldiv_busy}
// Counter checks are compiled in only with HAZARD_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

   localparam int LAT = 4;
   localparam int CW  = 4;

   localparam logic [5:0] C_RUN    = 6'b110000;
   localparam logic [5:0] C_STALL  = 6'b000100;
   localparam logic [5:0] C_FLUSH  = 6'b111100;
   localparam logic [5:0] C_START  = 6'b110010;
   localparam logic [5:0] C_BUSY   = 6'b110001;
   localparam logic [5:0] C_BSTALL = 6'b000101;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   hazard_control_unit_if hif ();

`ifdef HAZARD_PERF_CNT_EN
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;
`endif

   hazard_control_unit #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (hif.slave)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] ctl();
      return {hif.pc_write, hif.if_id_write, hif.if_id_flush,
              hif.id_ex_bubble, hif.muldiv_start, hif.muldiv_busy};
   endfunction

   task automatic check_ctl(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      #1;
      obs = ctl();
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic check_cnt(input string tag, input logic [CW-1:0] obs,
                            input logic [CW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      hif.id_rs           = '0;
      hif.id_rt           = '0;
      hif.id_uses_rs      = 1'b0;
      hif.id_uses_rt      = 1'b0;
      hif.id_is_muldiv    = 1'b0;
      hif.id_reads_hilo   = 1'b0;
      hif.ex_mem_read     = 1'b0;
      hif.ex_rd           = '0;
      hif.ex_branch_taken = 1'b0;
   endtask

   task automatic load_use_8();
      hif.ex_mem_read = 1'b1;
      hif.ex_rd       = 5'd8;
      hif.id_rs       = 5'd8;
      hif.id_uses_rs  = 1'b1;
   endtask

   initial begin
      clear_in();
      // Reset state
      tick();
      check_ctl("reset_ctl", C_RUN);
      rst = 1'b0;
      tick();

      // Load-use on rs: single-cycle stall, then bubble clears ex_mem_read
      load_use_8();
      check_ctl("loaduse_rs", C_STALL);
      tick();
      hif.ex_mem_read = 1'b0;
      check_ctl("loaduse_release", C_RUN);
      tick();

      // Load into $zero never stalls
      hif.ex_mem_read = 1'b1;
      hif.ex_rd       = 5'd0;
      hif.id_rs       = 5'd0;
      check_ctl("loaduse_zero", C_RUN);
      tick();

      // Load-use on rt, then same registers but rt not read
      clear_in();
      hif.ex_mem_read = 1'b1;
      hif.ex_rd       = 5'd9;
      hif.id_rt       = 5'd9;
      hif.id_uses_rt  = 1'b1;
      check_ctl("loaduse_rt", C_STALL);
      tick();
      hif.id_uses_rt  = 1'b0;
      check_ctl("rt_not_used", C_RUN);
      tick();

      // Taken branch overrides a load-use match
      clear_in();
      load_use_8();
      hif.ex_branch_taken = 1'b1;
      check_ctl("branch_over_loaduse", C_FLUSH);
      tick();
      clear_in();
`ifdef HAZARD_PERF_CNT_EN
      check_cnt("stall_cnt_after_branch", stall_cnt, 4'd2);
      check_cnt("flush_cnt_after_branch", flush_cnt, 4'd1);
`endif
      check_ctl("post_branch", C_RUN);

      // Mult at T, mfhi held from T+1: stall T+1..T+4, proceed at T+5
      hif.id_is_muldiv = 1'b1;
      check_ctl("md_issue", C_START);
      tick();
      hif.id_is_muldiv  = 1'b0;
      hif.id_reads_hilo = 1'b1;
      for (int i = 1; i <= LAT; i++) begin
         check_ctl($sformatf("mfhi_stall_T%0d", i), C_BSTALL);
         tick();
      end
      check_ctl("mfhi_proceed", C_RUN);

      // Back-to-back mult/div: second issue waits out the first
      hif.id_reads_hilo = 1'b0;
      hif.id_is_muldiv  = 1'b1;
      check_ctl("md_issue2", C_START);
      tick();
      for (int i = 1; i <= LAT; i++) begin
         check_ctl($sformatf("b2b_stall_T%0d", i), C_BSTALL);
         tick();
      end
      check_ctl("b2b_start", C_START);
      tick();

      // Independent ALU ops flow during MD_BUSY; load-use still stalls
      hif.id_is_muldiv = 1'b0;
      for (int i = 1; i <= LAT; i++) begin
         if (i == 2) begin
            load_use_8();
            check_ctl("busy_loaduse", C_BSTALL);
            clear_in();
         end else begin
            check_ctl($sformatf("alu_busy_T%0d", i), C_BUSY);
         end
         tick();
      end
      check_ctl("busy_drop", C_RUN);

      // Reset pulsed at T+2 of a mult/div clears busy without a clock edge
      hif.id_is_muldiv = 1'b1;
      check_ctl("md_issue3", C_START);
      tick();
      hif.id_is_muldiv = 1'b0;
      tick();
      check_ctl("busy_T2", C_BUSY);
      rst = 1'b1;
      check_ctl("rst_async", C_RUN);
      tick();
      rst = 1'b0;
      hif.id_is_muldiv = 1'b1;
      check_ctl("md_after_rst", C_START);
      tick();
      hif.id_is_muldiv = 1'b0;
      check_ctl("busy_after_rst", C_BUSY);
`ifdef HAZARD_PERF_CNT_EN
      check_cnt("stall_cnt_after_rst", stall_cnt, 4'd0);
      check_cnt("flush_cnt_after_rst", flush_cnt, 4'd0);

      // Saturation: 20 stall cycles into a 4-bit counter
      load_use_8();
      for (int i = 0; i < 20; i++) tick();
      check_cnt("stall_cnt_sat", stall_cnt, 4'd15);
      check_cnt("flush_cnt_idle", flush_cnt, 4'd0);
      clear_in();
`endif
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the EX-stage forwarding logic and resolves the hazards forwarding cannot cover. It stalls PC and IF/ID and bubbles ID/EX on load-use dependencies. It flushes wrong-path instructions on taken branches and jumps. It sequences the multi-cycle mult/div unit, stalling dependent instructions until HI/LO are valid.

## Interface
Parameters:
- MULDIV_LAT, 4, mult/div execution cycles after issue; legal range 1..15
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  5  source register numbers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_is_muldiv  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of the EX instruction
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  insert NOP into ID/EX
- muldiv_start  out  1  one-cycle issue pulse to the mult/div unit
- muldiv_busy  out  1  mult/div unit is executing; HI/LO are not yet valid
- stall_cnt, flush_cnt  out  CNT_W each  performance counters; present only with HAZARD_PERF_CNT_EN

## Operation
- load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs & ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- md_hazard = (state == MD_BUSY) & (id_is_muldiv | id_reads_hilo).
- stall = (load_use | md_hazard) & ~ex_branch_taken. The flush has priority because the ID instruction is on the wrong path.
- Flush cycle (ex_branch_taken = 1): if_id_flush = 1, id_ex_bubble = 1, pc_write = 1, if_id_write = 1.
- Stall cycle: pc_write = 0, if_id_write = 0, id_ex_bubble = 1, if_id_flush = 0.
- Otherwise: pc_write = 1, if_id_write = 1, id_ex_bubble = 0, if_id_flush = 0.
- muldiv_start = id_is_muldiv & (state == RUN) & ~stall & ~ex_branch_taken.
- The FSM has two states, RUN and MD_BUSY, with down-counter md_cnt of width clog2(MULDIV_LAT+1).
  - RUN: when muldiv_start = 1, go to MD_BUSY and set md_cnt = MULDIV_LAT.
  - MD_BUSY: decrement md_cnt each cycle. When md_cnt == 1, go to RUN and set md_cnt to 0.
  - A taken branch does not abort MD_BUSY. The issued mult/div is older than the branch.
- muldiv_busy = (state == MD_BUSY).
- Non-HI/LO instructions flow freely during MD_BUSY. Load-use stalls still apply.

## Timing
- All hazard outputs are combinational from inputs and state, and are valid in the same cycle. muldiv_busy is decoded from registered state.
- Load-use stall lasts exactly 1 cycle. The bubble clears ex_mem_read on the next cycle, and forwarding covers the MEM-stage load.
- A mult/div issued in cycle T sets muldiv_busy = 1 for cycles T+1 through T+MULDIV_LAT.
  - An mfhi held in ID stalls through T+MULDIV_LAT and proceeds at T+MULDIV_LAT+1.
  - A back-to-back mult/div follows the same timing: muldiv_start pulses at T+MULDIV_LAT+1.
- Reset values (rst = 1, inputs 0): state RUN, md_cnt 0, pc_write 1, if_id_write 1, if_id_flush 0, id_ex_bubble 0, muldiv_start 0, muldiv_busy 0, counters 0.
- Reset asserted mid-MD_BUSY forces RUN and clears muldiv_busy immediately, without waiting for a clock edge.
- ex_rd == 0 never produces a stall.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt and flush_cnt ports exist.
  - stall_cnt increments every cycle with stall = 1.
  - flush_cnt increments every cycle with ex_branch_taken = 1.
  - Both saturate at all-ones and reset to 0.
- HAZARD_PERF_CNT_EN undefined: the ports and counter logic are absent. Hazard behaviour is identical.

## Structure
- Shared pipeline package holds the state encoding (RUN = 1'b0, MD_BUSY = 1'b1), the REG_ZERO = 5'd0 constant, and the register-address width of 5.
- One sub-module, sat_counter: a CNT_W-bit saturating counter with an increment enable and async active-high reset. It is instantiated twice, only under HAZARD_PERF_CNT_EN.

## Test plan
- Load-use: ex_mem_read = 1, ex_rd = 8, id_rs = 8, id_uses_rs = 1 -> pc_write = 0, if_id_write = 0, id_ex_bubble = 1 for 1 cycle. With ex_rd = 0 -> no stall.
- Branch during load-use: ex_branch_taken = 1 while the load-use match holds -> if_id_flush = 1, id_ex_bubble = 1, pc_write = 1; stall_cnt unchanged, flush_cnt +1.
- Mult then mfhi, MULDIV_LAT = 4: id_is_muldiv = 1 at T -> muldiv_start = 1 at T; muldiv_busy = 1 for T+1..T+4. With id_reads_hilo = 1 held from T+1 -> stalls for 4 cycles and proceeds at T+5.
- Independent ALU ops during MD_BUSY -> no stall; muldiv_busy still drops after exactly 4 cycles.
- rst pulsed at T+2 of a mult/div -> muldiv_busy = 0 immediately. The next id_is_muldiv after reset release issues with no stall.
- Saturation, CNT_W = 4: hold stall for 20 cycles -> stall_cnt stays at 15.
